flash_prefetch_queue: RTL and testbench

Parametrised instruction-fetch front end between the flash controller and the CPU core. It issues sequential word reads over the flash request/ready handshake and buffers returned words in a DEPTH-entry FIFO. It presents them to the core with a valid/take handshake, tagged with their fetch address. It also supports redirects (jumps) with flush, and a halt input that stops new requests.

---
 rtl/flash_prefetch_queue.sv | 142 ++++++++++++++
 tb/tb_flash_prefetch_queue.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_prefetch_queue.sv
// Sequential instruction prefetcher: one flash read at a time into a DEPTH-entry FIFO,
// with redirect/flush and halt. Define FLASH_PREFETCH_PERF_EN to add the stallCycles counter.
module flash_prefetch_queue #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 24,
  parameter int DEPTH      = 4,
  parameter int ADDR_STEP  = 2,
  parameter int START_ADDR = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [ADDR_W-1:0]          flashReadAddr,
  output logic                       flashEnabled,
  input  logic [DATA_W-1:0]          flashByteRead,
  input  logic                       flashDataReady,
  output logic [DATA_W-1:0]          instr,
  output logic [ADDR_W-1:0]          instrAddr,
  output logic                       instrValid,
  input  logic                       instrTake,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirectAddr,
  input  logic                       halt,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef FLASH_PREFETCH_PERF_EN
  ,
  output logic [15:0]                stallCycles
`endif
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] fetch_ptr;
  logic              discard;
  logic              start_req;
  logic              capture;
  logic              push;
  logic              pop;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_req  = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        // a redirect in this cycle empties the FIFO, so space is guaranteed
        if (!halt && ((count < FULL) || redirect)) begin
          state_next = REQ;
          start_req  = 1'b1;
        end
      end
      REQ: begin
        if (flashDataReady) begin
          state_next = DRAIN;
          capture    = 1'b1;
        end
      end
      DRAIN: begin
        if (!flashDataReady) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign push       = capture && !discard && !redirect;
  assign pop        = instrTake && instrValid && !redirect;
  assign instrValid = (count != '0);
  assign instr      = data_mem[rd_ptr];
  assign instrAddr  = addr_mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flashEnabled  <= 1'b0;
      flashReadAddr <= ADDR_W'(START_ADDR);
      fetch_ptr     <= ADDR_W'(START_ADDR);
      discard       <= 1'b0;
    end else begin
      if (start_req) begin
        flashEnabled  <= 1'b1;
        flashReadAddr <= redirect ? redirectAddr : fetch_ptr;
      end else if (capture) begin
        flashEnabled  <= 1'b0;
      end
      // a redirect while a read is in flight marks that word to be dropped on arrival
      if (redirect) begin
        fetch_ptr <= redirectAddr;
        discard   <= (state == REQ) && !capture;
      end else if (capture) begin
        discard <= 1'b0;
        if (!discard) fetch_ptr <= fetch_ptr + ADDR_W'(ADDR_STEP);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        addr_mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= flashByteRead;
        addr_mem[wr_ptr] <= fetch_ptr;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

`ifdef FLASH_PREFETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stallCycles <= 16'd0;
    else if (!instrValid && !halt && (stallCycles != 16'hFFFF))
      stallCycles <= stallCycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_flash_prefetch_queue.sv
// Bench for flash_prefetch_queue: flash responder, queue-based reference model checked
// every cycle, and directed phases for fill, take, halt, redirect and async reset.
module tb_flash_prefetch_queue;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 24;
  localparam int DEPTH      = 4;
  localparam int ADDR_STEP  = 2;
  localparam int START_ADDR = 0;
  localparam int LAT        = 2;
  localparam int HOLD       = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] flashReadAddr;
  logic              flashEnabled;
  logic [DATA_W-1:0] flashByteRead;
  logic              flashDataReady;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instrAddr;
  logic              instrValid;
  logic              instrTake;
  logic              redirect;
  logic [ADDR_W-1:0] redirectAddr;
  logic              halt;
  logic [2:0]        count;
`ifdef FLASH_PREFETCH_PERF_EN
  logic [15:0]       stallCycles;
`endif

  flash_prefetch_queue #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .ADDR_STEP(ADDR_STEP), .START_ADDR(START_ADDR)
  ) dut (
    .clk(clk), .reset(reset),
    .flashReadAddr(flashReadAddr), .flashEnabled(flashEnabled),
    .flashByteRead(flashByteRead), .flashDataReady(flashDataReady),
    .instr(instr), .instrAddr(instrAddr), .instrValid(instrValid), .instrTake(instrTake),
    .redirect(redirect), .redirectAddr(redirectAddr), .halt(halt), .count(count)
`ifdef FLASH_PREFETCH_PERF_EN
    , .stallCycles(stallCycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  entry_t q[$];

  int compared = 0;
  int mismatched = 0;

  logic [ADDR_W-1:0] model_ptr = ADDR_W'(START_ADDR);
  logic              discard_m = 1'b0;
  logic              outstanding = 1'b0;
  logic              gate_ok = 1'b0;
  logic              raised;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [ADDR_W-1:0] last_req_addr = '0;
  int                resp_wait = 0;
  int                resp_hi = 0;
  int                req_count = 0;
  int                capture_count = 0;
  int                stall_m = 0;
  int                size0;

  function automatic logic [DATA_W-1:0] fmem(input logic [ADDR_W-1:0] a);
    case (a)
      24'h000000: fmem = 16'h0002;
      24'h000002: fmem = 16'h0201;
      24'h000004: fmem = 16'h0402;
      24'h000006: fmem = 16'h0602;
      default:    fmem = a[15:0] ^ 16'h8000;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic bound_check(input string name, input logic ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL %s: wait bound expired", name);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic applyStimulus(input logic take, input logic redir, input logic [ADDR_W-1:0] raddr,
                               input logic hlt, input int cycles);
    instrTake    = take;
    redirect     = redir;
    redirectAddr = raddr;
    halt         = hlt;
    tick(cycles);
  endtask

  // Per-cycle: compare against the model, run the flash responder, then advance the
  // model across the coming rising edge using the inputs that edge will see.
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("rst_en", 32'(flashEnabled), 32'd0);
      checkOutput("rst_raddr", 32'(flashReadAddr), START_ADDR);
      checkOutput("rst_count", 32'(count), 32'd0);
      checkOutput("rst_valid", 32'(instrValid), 32'd0);
      checkOutput("rst_instr", 32'(instr), 32'd0);
      checkOutput("rst_iaddr", 32'(instrAddr), 32'd0);
`ifdef FLASH_PREFETCH_PERF_EN
      checkOutput("rst_stall", 32'(stallCycles), 32'd0);
`endif
      q.delete();
      model_ptr      = ADDR_W'(START_ADDR);
      discard_m      = 1'b0;
      outstanding    = 1'b0;
      gate_ok        = 1'b0;
      flashDataReady = 1'b0;
      resp_hi        = 0;
      resp_wait      = 0;
      stall_m        = 0;
    end else begin
      checkOutput("count", 32'(count), q.size());
      checkOutput("valid", 32'(instrValid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        checkOutput("instr", 32'(instr), 32'(q[0].data));
        checkOutput("instr_addr", 32'(instrAddr), 32'(q[0].addr));
      end
      if (outstanding) begin
        checkOutput("en_hold", 32'(flashEnabled), 32'd1);
        checkOutput("addr_hold", 32'(flashReadAddr), 32'(req_addr));
      end
      if (flashDataReady) checkOutput("en_drain", 32'(flashEnabled), 32'd0);
`ifdef FLASH_PREFETCH_PERF_EN
      checkOutput("stall", 32'(stallCycles), stall_m);
`endif

      raised = 1'b0;
      if (flashDataReady) begin
        resp_hi--;
        if (resp_hi == 0) flashDataReady = 1'b0;
      end else if (outstanding) begin
        if (resp_wait > 0) resp_wait--;
        if (resp_wait == 0) begin
          flashDataReady = 1'b1;
          flashByteRead  = fmem(req_addr);
          resp_hi        = HOLD;
          raised         = 1'b1;
        end
      end else if (flashEnabled) begin
        checkOutput("req_addr", 32'(flashReadAddr), 32'(model_ptr));
        checkOutput("req_gate", 32'(gate_ok), 32'd1);
        outstanding   = 1'b1;
        req_addr      = flashReadAddr;
        last_req_addr = flashReadAddr;
        resp_wait     = LAT;
        req_count++;
      end

      size0   = q.size();
      gate_ok = !halt && ((size0 < DEPTH) || redirect);
      if (!halt && size0 == 0 && stall_m < 65535) stall_m++;
      if (raised) capture_count++;
      if (redirect) begin
        q.delete();
        model_ptr = redirectAddr;
        discard_m = outstanding && !raised;
        if (raised) outstanding = 1'b0;
      end else begin
        if (instrTake && size0 > 0) void'(q.pop_front());
        if (raised) begin
          outstanding = 1'b0;
          if (discard_m) discard_m = 1'b0;
          else begin
            q.push_back({fmem(model_ptr), model_ptr});
            model_ptr = model_ptr + ADDR_W'(ADDR_STEP);
          end
        end
      end
    end
  end

  initial begin : directed
    int n;
    int caps;
    int reqs;
    logic [ADDR_W-1:0] next_addr;
    logic [15:0] pat;
    reset = 1'b0; instrTake = 1'b0; redirect = 1'b0; redirectAddr = '0;
    halt = 1'b0; flashDataReady = 1'b0; flashByteRead = '0;
    pat = 16'b1011_0010_1101_0110;
    tick(3);
    reset = 1'b1;

    // Fill with no takes: four requests, then the queue stops fetching.
    n = 0;
    while (q.size() < 4 && n < 200) begin tick(1); n++; end
    bound_check("fill4", q.size() >= 4);
    tick(10);
    checkOutput("full_count", 32'(count), 32'd4);
    checkOutput("full_head", 32'(instr), 32'h0002);
    checkOutput("full_head_addr", 32'(instrAddr), 32'd0);
    checkOutput("full_en", 32'(flashEnabled), 32'd0);
    checkOutput("full_reqs", req_count, 32'd4);
    checkOutput("full_caps", capture_count, 32'd4);

    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 0);
    checkOutput("take1_count", 32'(count), 32'd3);
    checkOutput("take1_head", 32'(instr), 32'h0201);
    checkOutput("take1_head_addr", 32'(instrAddr), 32'd2);
    n = 0;
    while (q.size() < 4 && n < 50) begin tick(1); n++; end
    bound_check("refill", q.size() >= 4);
    checkOutput("refill_reqs", req_count, 32'd5);
    checkOutput("refill_addr", 32'(last_req_addr), 32'h000008);

    // Irregular takes so pops coincide with captures at various occupancies.
    for (int i = 0; i < 48; i++) applyStimulus(pat[i % 16], 1'b0, '0, 1'b0, 1);

    applyStimulus(1'b1, 1'b0, '0, 1'b0, 12);
    n = 0;
    while (!(outstanding && !flashDataReady) && n < 50) begin tick(1); n++; end
    bound_check("halt_wait", outstanding && !flashDataReady);
    caps = capture_count;
    reqs = req_count;
    next_addr = last_req_addr + ADDR_W'(ADDR_STEP);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 30);
    checkOutput("halt_caps", capture_count, caps + 1);
    checkOutput("halt_reqs", req_count, reqs);
    checkOutput("halt_en", 32'(flashEnabled), 32'd0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 0);
    n = 0;
    while (req_count == reqs && n < 20) begin tick(1); n++; end
    bound_check("resume", req_count > reqs);
    checkOutput("resume_addr", 32'(last_req_addr), 32'(next_addr));

    applyStimulus(1'b1, 1'b0, '0, 1'b0, 6);
    applyStimulus(1'b0, 1'b1, 24'h000200, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 0);
    n = 0;
    while (!(outstanding && req_addr == 24'h000200 && !flashDataReady) && n < 40) begin tick(1); n++; end
    bound_check("req_200", outstanding && req_addr == 24'h000200);
    applyStimulus(1'b1, 1'b1, 24'h000100, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 0);
    checkOutput("redir_count", 32'(count), 32'd0);
    checkOutput("redir_valid", 32'(instrValid), 32'd0);
    n = 0;
    while (q.size() == 0 && n < 40) begin tick(1); n++; end
    bound_check("redir_fill", q.size() != 0);
    checkOutput("redir_req_addr", 32'(last_req_addr), 32'h000100);
    checkOutput("redir_head", 32'(instr), 32'h8100);
    checkOutput("redir_head_addr", 32'(instrAddr), 32'h000100);

    n = 0;
    while (!(outstanding && !flashDataReady) && n < 40) begin tick(1); n++; end
    bound_check("rst_wait", outstanding && !flashDataReady);
    checkOutput("pre_rst_en", 32'(flashEnabled), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("async_en", 32'(flashEnabled), 32'd0);
    checkOutput("async_count", 32'(count), 32'd0);
`ifdef FLASH_PREFETCH_PERF_EN
    checkOutput("async_stall", 32'(stallCycles), 32'd0);
`endif
    tick(3);
    reset = 1'b1;
    tick(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
